// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_pkg
// Brief    : Shared types and helpers for the round-robin stream multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    localparam int MAX_N = 64;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin search from ptr, wrapping N-1 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Brief    : N-to-1 packet-aware round-robin stream mux with registered output.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_sel,
    input  logic                 out_ready
);

    localparam int SEL_W = $clog2(N);

    state_t             state_q,     state_d;
    logic [SEL_W-1:0]   lock_ch_q,   lock_ch_d;
    logic [SEL_W-1:0]   ptr_q,       ptr_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q,  out_last_d;
    logic [SEL_W-1:0]   out_sel_q,   out_sel_d;

    logic [N-1:0]       lock_mask;
    logic [N-1:0]       req;
    logic [N-1:0]       grant;
    logic [SEL_W-1:0]   grant_idx;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_last;
    logic               load;
    logic               in_xfer;

    // While locked, only the owning channel may request; it is not replaced if it idles.
    always_comb begin
        lock_mask            = '0;
        lock_mask[lock_ch_q] = 1'b1;
        req = (state_q == ST_LOCKED) ? (in_valid & lock_mask) : in_valid;
    end

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = SEL_W'(onehot_to_idx(MAX_N'(grant)));
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_last = in_last[i];
            end
        end
        load     = ~out_valid_q | out_ready;
        in_ready = reset_n ? (grant & {N{load}}) : '0;
        in_xfer  = |(in_ready & in_valid);
    end

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (in_xfer) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (sel_last) begin
                state_d = ST_IDLE;
                ptr_d   = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
            end else begin
                state_d   = ST_LOCKED;
                lock_ch_d = grant_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Brief    : Self-checking bench for stream_mux_rr with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic [1:0]         out_sel;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: packet ownership, round-robin pointer and output register.
    bit         m_locked;
    int         m_lock_ch;
    int         m_ptr;
    bit         m_ov;
    logic [7:0] m_od;
    bit         m_ol;
    int         m_os;

    stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int model_winner();
        if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w;
        w = model_winner();
        if (!reset_n || w < 0 || !(!m_ov || out_ready)) return '0;
        return N'(1) << w;
    endfunction

    task automatic tick();
        int w;
        bit xfer;
        w    = model_winner();
        xfer = reset_n && (w >= 0) && (!m_ov || out_ready);
        @(posedge clk);
        if (!reset_n) begin
            m_locked = 0; m_lock_ch = 0; m_ptr = 0;
            m_ov = 0; m_od = 0; m_ol = 0; m_os = 0;
        end else if (xfer) begin
            m_ov = 1;
            m_od = in_data[w*WIDTH +: WIDTH];
            m_ol = in_last[w];
            m_os = w;
            if (in_last[w]) begin
                m_locked = 0;
                m_ptr    = (w + 1) % N;
            end else begin
                m_locked  = 1;
                m_lock_ch = w;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy);
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        in_data   = $urandom;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(4'b1111, 4'b0000, 1'b1);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 4'b0101, 1'b1);
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
            end
            tick();
        end
        checks++;
        if ({out_valid, out_data, out_last, out_sel} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%0d expected all zero",
                     out_valid, out_data, out_last, out_sel);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_rr_all();
        int exp_sel [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_d;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 4'b1111, 1'b1);
            exp_d = in_data[exp_sel[k]*WIDTH +: WIDTH];
            checks++;
            if (in_ready !== (4'b0001 << exp_sel[k])) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b expected channel %0d", k, in_ready, exp_sel[k]);
            end
            tick();
            checks++;
            if (!out_valid || out_sel !== 2'(exp_sel[k]) || out_data !== exp_d) begin
                errors++;
                $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                         k, out_valid, out_sel, out_data, exp_sel[k], exp_d);
            end
        end
    endtask

    task automatic test_packet();
        int exp_sel [4] = '{2, 2, 2, 0};
        logic [3:0] lasts [4] = '{4'b0001, 4'b0001, 4'b0101, 4'b0001};
        logic [3:0] valids [4] = '{4'b0101, 4'b0101, 4'b0101, 4'b0001};
        do_reset();
        drive(4'b0001, 4'b0001, 1'b1);   // single-beat ch0 packet moves ptr to 1
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(valids[k], lasts[k], 1'b1);
            checks++;
            if (in_ready !== (4'b0001 << exp_sel[k])) begin
                errors++; $display("FAIL pkt_ready[%0d]: got %b expected channel %0d", k, in_ready, exp_sel[k]);
            end
            tick();
            checks++;
            if (out_sel !== 2'(exp_sel[k])) begin
                errors++; $display("FAIL pkt_sel[%0d]: got %0d expected %0d", k, out_sel, exp_sel[k]);
            end
        end
        // ptr moved to 3 after the ch2 packet and to 1 after ch0: ch1 beats ch3.
        drive(4'b1010, 4'b1010, 1'b1);
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL pkt_ptr: got %b expected 0010", in_ready);
        end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        drive(4'b0001, 4'b0001, 1'b0);
        in_data[7:0] = 8'hA5;
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL stall_ready[%0d]: got %b expected 0000", c, in_ready);
            end
            tick();
            checks++;
            if (!out_valid || out_data !== 8'hA5 || out_sel !== 2'd0 || !out_last) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%0d l=%b expected v=1 d=a5 s=0 l=1",
                         c, out_valid, out_data, out_sel, out_last);
            end
        end
        drive(4'b0000, 4'b0000, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(4'b1000, 4'b1000, 1'b1);
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_ready: got %b expected 1000", in_ready);
        end
        tick();
        checks++;
        if (!out_valid || out_sel !== 2'd3) begin
            errors++; $display("FAIL wrap_sel: got v=%b s=%0d expected v=1 s=3", out_valid, out_sel);
        end
        drive(4'b1011, 4'b1011, 1'b1);
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_ptr: got %b expected 0001", in_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(4'b0010, 4'b0000, 1'b1);
        tick();
        reset_n = 1'b0;
        drive(4'b0011, 4'b0000, 1'b1);
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL rstmid_ready: got %b expected 0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid);
        end
        reset_n = 1'b1;
        drive(4'b0011, 4'b0000, 1'b1);
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL rstmid_grant: got %b expected 0001", in_ready);
        end
        tick();
        checks++;
        if (!out_valid || out_sel !== 2'd0) begin
            errors++; $display("FAIL rstmid_sel: got v=%b s=%0d expected v=1 s=0", out_valid, out_sel);
        end
    endtask

    task automatic test_lock_drop();
        do_reset();
        drive(4'b0010, 4'b0000, 1'b1);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(4'b0001, 4'b0001, 1'b1);
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL lock_ready[%0d]: got %b expected 0000", c, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL lock_valid[%0d]: got %b expected 0", c, out_valid);
            end
        end
        drive(4'b0011, 4'b0011, 1'b1);
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL lock_last: got %b expected 0010", in_ready);
        end
        tick();
        drive(4'b0001, 4'b0001, 1'b1);
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL lock_release: got %b expected 0001", in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            drive(N'($urandom), N'($urandom_range(0, 3) == 0 ? 4'b0000 : $urandom),
                  ($urandom_range(0, 3) != 0));
            exp_rdy = model_ready();
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (out_valid !== m_ov ||
                (m_ov && (out_data !== m_od || out_last !== m_ol || out_sel !== 2'(m_os)))) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h l=%b s=%0d expected v=%b d=%h l=%b s=%0d",
                         c, out_valid, out_data, out_last, out_sel, m_ov, m_od, m_ol, m_os);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        m_locked = 0; m_lock_ch = 0; m_ptr = 0;
        m_ov = 0; m_od = 0; m_ol = 0; m_os = 0;
        test_reset();
        test_rr_all();
        test_packet();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_lock_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
